// File: rtl/layer_cfg_sequencer.sv
// Layer configuration sequencer: loads, validates and launches one layer, then returns a response.
// Optional macro LAYER_CYCLE_COUNT_EN enables the run-cycle counter reported in rsp_cycles.
module layer_cfg_sequencer #(
  parameter int NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_addr,
  input  logic [15:0]              cfg_data,
  input  logic                     cfg_last,
  output logic [NUM_REGS*16-1:0]   cfg_bus,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_status,
  output logic [31:0]              rsp_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [NUM_REGS-1:0] MASK_FULL = {NUM_REGS{1'b1}};

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_mask;
  logic [1:0]          r_status;
  logic                r_first;
  logic                w_accept;
  logic                w_illegal;

  assign w_accept = cfg_valid & cfg_ready;

  // Zero-valued geometry fields or a filter larger than the input map are rejected.
  always_comb begin
    w_illegal = (r_regs[3] > r_regs[1]) || (r_regs[4] > r_regs[2]);
    for (int i = 1; i < 8; i++) begin
      if (r_regs[i] == 16'd0) w_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = cfg_last ? S_CHECK : S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && cfg_last) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (r_mask != MASK_FULL || w_illegal) w_next = S_RESP;
        else                                  w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_first && core_done) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    core_start = (r_state == S_RUN) && r_first;
    rsp_valid  = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 16'd0;
      r_mask   <= '0;
      r_status <= 2'b00;
      r_first  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_regs[cfg_addr] <= cfg_data;
        r_mask[cfg_addr] <= 1'b1;
      end
      if (r_state == S_RESP && rsp_ready) r_mask <= '0;
      r_first <= (r_state == S_CHECK) && (w_next == S_RUN);
      // Status is settled in CHECK and held unchanged through RUN and RESP.
      if (r_state == S_CHECK) begin
        if (r_mask != MASK_FULL) r_status <= 2'b10;
        else if (w_illegal)      r_status <= 2'b01;
        else                     r_status <= 2'b00;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
    assign cfg_bus[g*16 +: 16] = r_regs[g];
  end

  assign rsp_status = r_status;

`ifdef LAYER_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  // Cleared on the word that enters CHECK, so error responses report zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycles <= 32'd0;
    end else if (w_accept && cfg_last) begin
      r_cycles <= 32'd0;
    end else if (r_state == S_RUN && r_cycles != 32'hFFFF_FFFF) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign rsp_cycles = r_cycles;
`else
  assign rsp_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_layer_cfg_sequencer.sv
// Scoreboard bench for layer_cfg_sequencer; expectations adapt to LAYER_CYCLE_COUNT_EN.
module tb_layer_cfg_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [2:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         cfg_last;
  logic [127:0] cfg_bus;
  logic         core_start;
  logic         core_done;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_status;
  logic [31:0]  rsp_cycles;

  layer_cfg_sequencer #(.NUM_REGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .cfg_bus    (cfg_bus),
    .core_start (core_start),
    .core_done  (core_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_cycles (rsp_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] cyc;
  } rsp_t;

  rsp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          start_cnt = 0;
  logic [15:0] sh_regs [8];
  logic [7:0]  sh_mask;

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_status();
    logic bad;
    if (sh_mask != 8'hFF) return 2'b10;
    bad = (sh_regs[3] > sh_regs[1]) || (sh_regs[4] > sh_regs[2]);
    for (int i = 1; i < 8; i++) if (sh_regs[i] == 16'd0) bad = 1'b1;
    return bad ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [127:0] shadow_bus();
    logic [127:0] b;
    for (int i = 0; i < 8; i++) b[i*16 +: 16] = sh_regs[i];
    return b;
  endfunction

  // Expected response for the config just loaded; n is the core_done delay after core_start.
  task automatic push_exp(input int n);
    rsp_t e;
    e.st  = model_status();
    e.cyc = 32'd0;
`ifdef LAYER_CYCLE_COUNT_EN
    if (e.st == 2'b00) e.cyc = 32'(n + 1);
`endif
    sb.push_back(e);
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic last);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_last  = last;
    cfg_valid = 1'b1;
    check("cfg_ready_load", {127'd0, cfg_ready}, 128'd1);
    step();
    cfg_valid   = 1'b0;
    cfg_last    = 1'b0;
    sh_regs[a]  = d;
    sh_mask[a]  = 1'b1;
  endtask

  task automatic load_regs(input logic [127:0] v, input int nwords);
    for (int i = 0; i < nwords; i++)
      write_word(3'(i), v[i*16 +: 16], i == nwords - 1);
    check("cfg_bus", cfg_bus, shadow_bus());
    check("cfg_ready_check", {127'd0, cfg_ready}, 128'd0);
  endtask

  task automatic run_core(input int n, input logic done_in_start);
    step();
    check("core_start_first", {127'd0, core_start}, 128'd1);
    core_done = done_in_start;
    step();
    core_done = 1'b0;
    check("core_start_once", {127'd0, core_start}, 128'd0);
    repeat (n - 1) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  task automatic expect_rsp(input int hold);
    rsp_t e;
    int   t = 0;
    while (rsp_valid !== 1'b1 && t < 300) begin
      step();
      t++;
    end
    check("rsp_valid_timeout", {127'd0, rsp_valid}, 128'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 128'd0, 128'd1);
    end else begin
      e = sb.pop_front();
      check("rsp_status", {126'd0, rsp_status}, {126'd0, e.st});
      check("rsp_cycles", {96'd0, rsp_cycles}, {96'd0, e.cyc});
      check("cfg_ready_resp", {127'd0, cfg_ready}, 128'd0);
      for (int i = 0; i < hold; i++) begin
        step();
        check("rsp_valid_hold", {127'd0, rsp_valid}, 128'd1);
        check("rsp_status_hold", {126'd0, rsp_status}, {126'd0, e.st});
        check("rsp_cycles_hold", {96'd0, rsp_cycles}, {96'd0, e.cyc});
        check("cfg_ready_hold", {127'd0, cfg_ready}, 128'd0);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    sh_mask   = 8'h00;
    check("rsp_valid_after", {127'd0, rsp_valid}, 128'd0);
    check("cfg_ready_after", {127'd0, cfg_ready}, 128'd1);
  endtask

  localparam logic [127:0] CFG_OK    = {16'd4, 16'd96, 16'd3, 16'd11, 16'd11, 16'd227, 16'd227, 16'd1};
  localparam logic [127:0] CFG_STR0  = {16'd0, 16'd96, 16'd3, 16'd11, 16'd11, 16'd227, 16'd227, 16'd2};
  localparam logic [127:0] CFG_FILTH = {16'd4, 16'd96, 16'd3, 16'd11, 16'd13, 16'd227, 16'd12, 16'd3};

  initial begin
    int base;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0;
    cfg_last = 1'b0; core_done = 1'b0; rsp_ready = 1'b0;
    sh_mask = 8'h00;
    for (int i = 0; i < 8; i++) sh_regs[i] = 16'd0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    check("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check("rst_core_start", {127'd0, core_start}, 128'd0);
    check("rst_cfg_bus", cfg_bus, 128'd0);
    check("rst_rsp_status", {126'd0, rsp_status}, 128'd0);
    check("rst_rsp_cycles", {96'd0, rsp_cycles}, 128'd0);

    // Legal layer, core_done 99 cycles after core_start.
    base = start_cnt;
    load_regs(CFG_OK, 8);
    push_exp(99);
    run_core(99, 1'b0);
    expect_rsp(0);
    check("s1_starts", 128'(start_cnt - base), 128'd1);
    check("s1_regs_kept", cfg_bus, CFG_OK);

    // Incomplete: regs 0..6 only.
    base = start_cnt;
    load_regs(CFG_OK, 7);
    push_exp(0);
    expect_rsp(0);
    check("s2_starts", 128'(start_cnt - base), 128'd0);

    // Illegal: stride 0, then filter taller than ifmap.
    base = start_cnt;
    load_regs(CFG_STR0, 8);
    push_exp(0);
    expect_rsp(0);
    load_regs(CFG_FILTH, 8);
    push_exp(0);
    expect_rsp(0);
    check("s3_starts", 128'(start_cnt - base), 128'd0);

    // Overwritten stride, done in start cycle ignored, host back-pressure.
    base = start_cnt;
    write_word(3'd7, 16'd0, 1'b0);
    load_regs(CFG_OK, 8);
    push_exp(3);
    run_core(3, 1'b1);
    expect_rsp(5);
    check("s4_starts", 128'(start_cnt - base), 128'd1);

    // Reset mid-RUN.
    base = start_cnt;
    load_regs(CFG_OK, 8);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) sh_regs[i] = 16'd0;
    sh_mask = 8'h00;
    check("rr_cfg_bus", cfg_bus, 128'd0);
    check("rr_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check("rr_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    check("rr_core_start", {127'd0, core_start}, 128'd0);
    check("rr_rsp_cycles", {96'd0, rsp_cycles}, 128'd0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    repeat (3) step();
    check("rr_done_ignored", {127'd0, rsp_valid}, 128'd0);
    check("rr_ready_idle", {127'd0, cfg_ready}, 128'd1);
    check("rr_starts", 128'(start_cnt - base), 128'd1);

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_cfg_sequencer.md
LAYER_CFG_SEQUENCER -- requirements
Module: layer_cfg_sequencer

Interface
REQ-001 Parameter: NUM_REGS, 8, number of 16-bit layer configuration registers.
REQ-002 Ports (clock and reset first):
- clk, input, 1, single core clock; all logic is rising-edge.
- rst_n, input, 1, synchronous active-low reset.
- cfg_valid, input, 1, host config word valid.
- cfg_ready, output, 1, block can accept a config word.
- cfg_addr, input, 3, register index.
- cfg_data, input, 16, register value.
- cfg_last, input, 1, final word of the layer; starts validation.
- cfg_bus, output, NUM_REGS*16, flattened registers; reg0 occupies bits [15:0].
- core_start, output, 1, one-cycle pulse that launches the layer on the PE array.
- core_done, input, 1, PE array layer-complete indication.
- rsp_valid, output, 1, layer response valid.
- rsp_ready, input, 1, host accepts the response.
- rsp_status, output, 2, response code: 00 ok, 01 illegal config, 10 incomplete config.
- rsp_cycles, output, 32, layer run cycle count.
REQ-003 Register map: 0 layer_id, 1 ifmap_h, 2 ifmap_w, 3 filt_h, 4 filt_w, 5 in_ch, 6 out_ch, 7 stride.

Function
REQ-004 FSM states: IDLE, LOAD, CHECK, RUN, RESP. Reset state is IDLE.
REQ-005 cfg_ready SHALL be 1 in IDLE and LOAD, and 0 in all other states.
REQ-006 A word is accepted when cfg_valid and cfg_ready are both 1.
REQ-007 On acceptance, cfg_data is written to register cfg_addr and the corresponding bit of the 8-bit written-mask is set.
REQ-008 Repeat writes to the same address: the last write wins.
REQ-009 The first accepted word SHALL move IDLE to LOAD.
REQ-010 An accepted word with cfg_last=1 SHALL move the FSM to CHECK, from either IDLE or LOAD.
REQ-011 CHECK lasts exactly one cycle. The outcome is decided in this order:
- written-mask not 0xFF: go to RESP with status 10;
- any register 1..7 equal to 0, filt_h>ifmap_h, or filt_w>ifmap_w: go to RESP with status 01;
- otherwise: go to RUN.
REQ-012 core_start SHALL be 1 only in the first cycle of RUN.
REQ-013 core_done SHALL be ignored in the core_start cycle.
REQ-014 In RUN, core_done=1 SHALL move the FSM to RESP with status 00.
REQ-015 rsp_valid SHALL be 1 in every RESP cycle. rsp_status and rsp_cycles SHALL be stable while rsp_valid=1.
REQ-016 Leaving RESP (on rsp_valid and rsp_ready) SHALL:
- return the FSM to IDLE;
- clear the written-mask;
- retain the register contents.
REQ-017 Cycle counter:
- cleared to 0 on entry to CHECK;
- increments every RUN cycle, including the start cycle and the cycle in which core_done is observed;
- saturates at 0xFFFFFFFF.
REQ-018 If core_done is first observed N cycles after the core_start cycle, rsp_cycles SHALL equal N+1.
REQ-019 Error responses (status 01 or 10) SHALL report rsp_cycles=0.
REQ-020 cfg_bus SHALL reflect register contents combinationally from the registers, with no added latency.

Reset
REQ-021 When rst_n=0 at a clock edge, regardless of state (including mid-RUN and RESP), the block SHALL:
- set the FSM to IDLE;
- clear all registers, the written-mask and the counter;
- drive core_start=0, rsp_valid=0, rsp_status=00, rsp_cycles=0.
REQ-022 cfg_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-023 Macro LAYER_CYCLE_COUNT_EN:
- defined: the counter is implemented per REQ-017 to REQ-019;
- undefined: no counter logic is present and rsp_cycles is constant 0.
REQ-024 All other behaviour is identical with and without LAYER_CYCLE_COUNT_EN.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write regs 0..7 = {1,227,227,11,11,3,96,4} with cfg_last on reg 7; core_done asserted 99 cycles after core_start -> one core_start pulse, rsp_status=00, rsp_cycles=100.
- Write regs 0..6 only, cfg_last on reg 6 -> no core_start, rsp_status=10, rsp_cycles=0.
- Full config with stride=0, or filt_h=13 with ifmap_h=12 -> no core_start, rsp_status=01.
- rsp_ready held low for 5 cycles -> rsp_valid stays 1 and values stay stable; cfg_ready=0 until the handshake, then 1.
- rst_n pulsed low mid-RUN -> next cycle FSM in IDLE, cfg_bus=0, rsp_valid=0; a later core_done is ignored.
- Build without LAYER_CYCLE_COUNT_EN, run scenario 1 -> rsp_status=00, rsp_cycles=0.
